pulse_stretch_driver: RTL and testbench
=======================================

Name: pulse_stretch_driver

Overview:
Output-side companion to the push-button input conditioning. Takes single-cycle event ticks (e.g. a debounced button tick) and turns each one into a human-visible LED pulse of fixed length, separated by a guaranteed dark gap. Events that arrive while a pulse is in progress are queued in a saturating counter. Sits between the debounced event sources and board LEDs/indicators.

Parameters:
- ON_CYCLES, 5_000_000, LED-on duration in clk cycles (50 ms at 100 MHz); must be >= 1.
- GAP_CYCLES, 2_500_000, minimum LED-off gap after each pulse in clk cycles; must be >= 1.
- CNT_W, 4, width of the pending-event counter; maximum queue depth is 2^CNT_W-1.
- PWM_W, 4, width of the brightness duty input and the PWM counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_in  in  1  single-cycle event request; a multi-cycle high counts as one event per cycle
- clr_ovf  in  1  clears the sticky overflow flag
- duty  in  PWM_W  on-phase brightness; used only when PULSE_DRV_PWM_EN is defined, otherwise ignored
- led  out  1  registered LED drive
- busy  out  1  high whenever state != IDLE
- pending  out  CNT_W  number of queued events not yet started
- overflow  out  1  sticky flag: an event was dropped because the queue was full

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, timer=0, pending=0, overflow=0, led=0, busy=0, PWM counter=0.
- FSM states: IDLE, ON, GAP. Outputs are registered; led=1 exactly when state==ON (see Optional Feature).
- Start condition: start = (tick_in | pending!=0).
- IDLE: if start, go to ON, load timer=ON_CYCLES-1, and consume one event.
- ON: decrement timer; at timer==0, go to GAP and load timer=GAP_CYCLES-1.
- GAP: decrement timer; at timer==0, if start go directly to ON (consume one event), else go to IDLE.
- Latency: tick at cycle t in IDLE gives led=1 in cycles t+1 .. t+ON_CYCLES, then led=0 for at least GAP_CYCLES cycles.
- Pending counter update rules:
  - +1 on tick_in.
  - -1 on consume.
  - Tick and consume in the same cycle: net 0. A tick that starts a pulse from empty never enters the queue.
- Saturation: tick_in while pending==2^CNT_W-1 with no consume in that cycle drops the event and sets overflow. The count never wraps.
- overflow is sticky until clr_ovf. If clr_ovf and a new drop occur in the same cycle, set wins.
- Timer width: $clog2(max(ON_CYCLES, GAP_CYCLES)+1) bits, unsigned down-counter. No other arithmetic wraps.
- Reset mid-pulse: led and busy drop immediately (asynchronous) and the queue is lost.
- tick_in has no effect on ON or GAP timing beyond queueing.

Optional Feature:
- Macro: PULSE_DRV_PWM_EN.
- Defined: a free-running PWM_W-bit counter increments every cycle. During ON, led = (pwm_cnt < duty).
  - duty=0 keeps led dark for the whole pulse.
  - duty=2^PWM_W-1 gives (2^PWM_W-1)/2^PWM_W brightness.
  - FSM timing is unchanged; busy is unaffected.
- Undefined: no PWM counter is built, duty is unused, and led = (state==ON).

Decomposition:
- Package pulse_drv_pkg holds:
  - typedef enum logic [1:0] {IDLE, ON, GAP} pulse_state_t;
  - a constant function computing the timer width from ON_CYCLES/GAP_CYCLES.
- One natural sub-module: pulse_timer, a loadable down-counter with a load value input, load strobe and a zero flag. It is instantiated once and shared by the ON and GAP phases.

Test Plan (ON_CYCLES=4, GAP_CYCLES=2, CNT_W=2, macro undefined unless noted):
- Reset: assert reset with tick_in=1 -> led=0, busy=0, pending=0, overflow=0 throughout reset.
- Single tick at cycle 10 -> led=1 in cycles 11-14; busy=1 in cycles 11-16; state IDLE at cycle 17; pending stays 0.
- Ticks at cycles 10,11,12 -> pending goes 0,1,2, then drains to 0. Three pulses: led high 11-14, 17-20, 23-26; each gap exactly 2 cycles.
- Ticks at cycles 10-14 -> pending reaches 3, the cycle-14 tick is dropped, overflow=1 from cycle 15, and exactly 4 pulses follow. clr_ovf at cycle 40 -> overflow=0 at cycle 41.
- Tick on the last GAP cycle with pending=0 -> ON entered on the next cycle without passing through IDLE; busy never drops.
- Reset asserted mid-ON at cycle 12 -> led and busy low immediately and pending=0. After reset release a new tick gives a full 4-cycle pulse.
- PULSE_DRV_PWM_EN defined, PWM_W=2, duty=1 -> during each ON phase led=1 only when pwm_cnt==0; duty=0 -> led never high.

Source files
------------

// File: rtl/pulse_drv_pkg.sv
// Shared types and sizing helpers for the pulse stretch LED driver.
package pulse_drv_pkg;

  typedef enum logic [1:0] {IDLE, ON, GAP} pulse_state_t;

  // Wide enough to hold the larger of the two phase lengths.
  function automatic int timer_width(input int on_c, input int gap_c);
    int mx;
    mx = (on_c > gap_c) ? on_c : gap_c;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter shared by the ON and GAP phases; holds at zero.
module pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: load has priority, otherwise decrement until zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pulse_stretch_driver.sv
// Stretches event ticks into fixed LED pulses with a guaranteed dark gap.
// Optional PWM dimming during ON is enabled by defining PULSE_DRV_PWM_EN.
module pulse_stretch_driver
  import pulse_drv_pkg::*;
#(
  parameter int ON_CYCLES  = 5_000_000,
  parameter int GAP_CYCLES = 2_500_000,
  parameter int CNT_W      = 4,
  parameter int PWM_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             clr_ovf,
  input  logic [PWM_W-1:0] duty,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int TMR_W = timer_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  pulse_state_t     state_r, next_state_s;
  logic             led_r, busy_r, overflow_r;
  logic [CNT_W-1:0] pending_r, pending_nxt_s;
  logic             overflow_nxt_s, led_nxt_s;
  logic             start_s, consume_s, drop_s;
  logic             load_s, zero_s;
  logic [TMR_W-1:0] load_val_s;

  pulse_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (zero_s)
  );

  // Next-state, timer load and event-consume decode.
  always_comb begin
    start_s      = tick_in | (pending_r != {CNT_W{1'b0}});
    next_state_s = state_r;
    load_s       = 1'b0;
    load_val_s   = ON_LOAD;
    consume_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          next_state_s = ON;
          load_s       = 1'b1;
          consume_s    = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      ON: begin
        if (zero_s) begin
          next_state_s = GAP;
          load_s       = 1'b1;
          load_val_s   = GAP_LOAD;
        end else begin
          next_state_s = ON;
        end
      end
      GAP: begin
        if (zero_s && start_s) begin
          next_state_s = ON;
          load_s       = 1'b1;
          consume_s    = 1'b1;
        end else if (zero_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = GAP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // A consume without a tick implies a non-empty queue, so no underflow.
  always_comb begin
    drop_s        = tick_in & ~consume_s & (pending_r == CNT_MAX);
    pending_nxt_s = pending_r;
    if (tick_in && !consume_s && !drop_s) begin
      pending_nxt_s = pending_r + CNT_W'(1);
    end else if (!tick_in && consume_s) begin
      pending_nxt_s = pending_r - CNT_W'(1);
    end else begin
      pending_nxt_s = pending_r;
    end
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else if (clr_ovf) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

`ifdef PULSE_DRV_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_r, pwm_nxt_s;
  assign pwm_nxt_s = pwm_cnt_r + PWM_W'(1);

  // Free-running PWM counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= {PWM_W{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_nxt_s;
    end
  end

  // Compare against the value the counter takes in the cycle led is shown.
  assign led_nxt_s = (next_state_s == ON) && (pwm_nxt_s < duty);
`else
  logic unused_duty_s;
  assign unused_duty_s = ^duty;
  assign led_nxt_s     = (next_state_s == ON);
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      led_r      <= 1'b0;
      busy_r     <= 1'b0;
      pending_r  <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      led_r      <= led_nxt_s;
      busy_r     <= (next_state_s != IDLE);
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  assign led      = led_r;
  assign busy     = busy_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_pulse_stretch_driver.sv
// Directed, table-driven bench for pulse_stretch_driver (ON=4, GAP=2, CNT_W=2).
module tb_pulse_stretch_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [1:0] duty = 2'd1;
  logic       led, busy, overflow;
  logic [1:0] pending;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic       tick;
    logic       clr;
    logic       e_led;
    logic       e_busy;
    logic [1:0] e_pend;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[0:63];
  int   n_vec;

  pulse_stretch_driver #(
    .ON_CYCLES(4), .GAP_CYCLES(2), .CNT_W(2), .PWM_W(2)
  ) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .clr_ovf(clr_ovf),
    .duty(duty), .led(led), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_led"}, int'(led), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pend"}, int'(pending), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
  endtask

  // Reset with tick_in held high; outputs must stay zero throughout.
  task automatic do_reset();
    reset   = 1'b1;
    tick_in = 1'b1;
    clr_ovf = 1'b0;
    #1;
    check_zero("rst");
    for (int i = 0; i < 3; i++) begin
      step();
      check_zero("rst");
    end
    tick_in = 1'b0;
    reset   = 1'b0;
    cyc     = 0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < n_vec; i++) begin
`ifndef PULSE_DRV_PWM_EN
      check({tag, "_led"}, int'(led), int'(tbl[i].e_led));
`endif
      check({tag, "_busy"}, int'(busy), int'(tbl[i].e_busy));
      check({tag, "_pend"}, int'(pending), int'(tbl[i].e_pend));
      check({tag, "_ovf"}, int'(overflow), int'(tbl[i].e_ovf));
      tick_in = tbl[i].tick;
      clr_ovf = tbl[i].clr;
      step();
    end
    tick_in = 1'b0;
    clr_ovf = 1'b0;
  endtask

  initial begin
    // Single tick at cycle 10.
    do_reset();
    n_vec = 21;
    for (int c = 0; c < n_vec; c++)
      tbl[c] = '{c == 10, 1'b0, rng(c, 11, 14), rng(c, 11, 16), 2'd0, 1'b0};
    run_table("single");

    // Ticks at cycles 10, 11, 12: three back-to-back pulses.
    do_reset();
    n_vec = 31;
    for (int c = 0; c < n_vec; c++)
      tbl[c] = '{rng(c, 10, 12), 1'b0,
                 rng(c, 11, 14) | rng(c, 17, 20) | rng(c, 23, 26),
                 rng(c, 11, 28),
                 rng(c, 12, 12) ? 2'd1 : rng(c, 13, 16) ? 2'd2 :
                 rng(c, 17, 22) ? 2'd1 : 2'd0,
                 1'b0};
    run_table("three");

    // Ticks at cycles 10..14: saturation, drop, sticky overflow, clear at 40.
    do_reset();
    n_vec = 44;
    for (int c = 0; c < n_vec; c++)
      tbl[c] = '{rng(c, 10, 14), c == 40,
                 rng(c, 11, 14) | rng(c, 17, 20) | rng(c, 23, 26) | rng(c, 29, 32),
                 rng(c, 11, 34),
                 rng(c, 12, 12) ? 2'd1 : rng(c, 13, 13) ? 2'd2 :
                 rng(c, 14, 16) ? 2'd3 : rng(c, 17, 22) ? 2'd2 :
                 rng(c, 23, 28) ? 2'd1 : 2'd0,
                 rng(c, 15, 40)};
    run_table("ovf");

    // Tick on the last GAP cycle with an empty queue: straight back to ON.
    do_reset();
    n_vec = 26;
    for (int c = 0; c < n_vec; c++)
      tbl[c] = '{(c == 10) || (c == 16), 1'b0,
                 rng(c, 11, 14) | rng(c, 17, 20),
                 rng(c, 11, 22), 2'd0, 1'b0};
    run_table("gapstart");

    // Reset asserted mid-ON with one event queued.
    do_reset();
    while (cyc < 10) step();
    tick_in = 1'b1;
    step();
    step();
    tick_in = 1'b0;
`ifndef PULSE_DRV_PWM_EN
    check("midon_pre_led", int'(led), 1);
`endif
    check("midon_pre_pend", int'(pending), 1);
    reset = 1'b1;
    #1;
    check("midon_led", int'(led), 0);
    check("midon_busy", int'(busy), 0);
    check("midon_pend", int'(pending), 0);
    step();
    reset = 1'b0;
    step();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
`ifndef PULSE_DRV_PWM_EN
      check("after_rst_led", int'(led), (k < 4) ? 1 : 0);
`endif
      check("after_rst_busy", int'(busy), (k < 6) ? 1 : 0);
      step();
    end

`ifdef PULSE_DRV_PWM_EN
    // With a 4-cycle ON and 4-step PWM, duty=1 lights exactly one cycle.
    for (int d = 0; d < 2; d++) begin
      int highs;
      duty    = 2'(d);
      highs   = 0;
      tick_in = 1'b1;
      step();
      tick_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
        highs += int'(led);
        step();
      end
      check("pwm_highs", highs, d);
      for (int k = 0; k < 3; k++) begin
        check("pwm_gap_led", int'(led), 0);
        step();
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
